// File: rtl/register_bank_32.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_32
// Description : Bank of 32 WIDTH-bit registers with a single write port and a
//               sequential clear engine. A clear walks one register per cycle
//               from index 0 to 31, so it takes exactly 32 cycles. The write
//               port is blocked while the clear runs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1          clock; all state changes on the rising edge
//   reset_n    in   1          asynchronous active-low reset
//   wr_valid   in   1          write request valid
//   wr_ready   out  1          write accepted when high (IDLE only)
//   wr_addr    in   5          target register index
//   wr_data    in   WIDTH      write value
//   clr_req    in   1          start a 32-cycle sequential clear
//   clr_busy   out  1          clear sequence in progress
//   regs_flat  out  32*WIDTH   register i on bits [i*WIDTH +: WIDTH]
// Build option
//   REG0_ZERO_EN : when defined, register 0 is hard-wired to zero. Writes to
//                  address 0 still complete the handshake; the data is dropped.
// ============================================================================
module register_bank_32 #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4:0]            wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic [32*WIDTH-1:0]   regs_flat
);

`ifdef REG0_ZERO_EN
    localparam bit REG0_ZERO = 1'b1;
`else
    localparam bit REG0_ZERO = 1'b0;
`endif

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic [4:0] clr_cnt;
    logic       wr_accept;
    logic       clr_active;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. clr_req is only looked at in IDLE, so a request
    // during a clear neither restarts nor stretches it.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clr_req)          state_next = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == 5'd31) state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state only
    // ------------------------------------------------------------------
    always_comb begin
        wr_ready   = 1'b0;
        clr_busy   = 1'b0;
        clr_active = 1'b0;
        case (state)
            ST_IDLE:  wr_ready = 1'b1;
            ST_CLEAR: begin
                clr_busy   = 1'b1;
                clr_active = 1'b1;
            end
            default:  wr_ready = 1'b1;
        endcase
    end

    assign wr_accept = wr_valid && wr_ready;

    // ------------------------------------------------------------------
    // Clear counter. It is held at 0 in IDLE, so every clear starts at
    // register 0. In CLEAR it wraps 31 -> 0 on the same edge that returns
    // the FSM to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt <= 5'd0;
        end else if (clr_active) begin
            clr_cnt <= clr_cnt + 5'd1;
        end else begin
            clr_cnt <= 5'd0;
        end
    end

    // ------------------------------------------------------------------
    // Register storage. A write and a clear step can never hit the same
    // cycle: writes are accepted only in IDLE and clear steps only occur
    // in CLEAR.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (REG0_ZERO && (i == 0)) begin : g_zero
            assign regs_flat[i*WIDTH +: WIDTH] = '0;
        end else begin : g_ff
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else if (wr_accept && (wr_addr == 5'(i))) begin
                    q <= wr_data;
                end else if (clr_active && (clr_cnt == 5'(i))) begin
                    q <= '0;
                end
            end
            assign regs_flat[i*WIDTH +: WIDTH] = q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_bank_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank_32
// Description : Self-checking bench for register_bank_32 (WIDTH = 32).
//               Single-write vectors come from a table; the clear, overlap
//               and mid-clear reset cases are written out as sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank_32;

    localparam int W = 32;

`ifdef REG0_ZERO_EN
    localparam bit R0Z = 1'b1;
    localparam logic [31:0] R0EXP = 32'h0000_0000;
`else
    localparam bit R0Z = 1'b0;
    localparam logic [31:0] R0EXP = 32'h0000_1234;
`endif

    logic            clk;
    logic            reset_n;
    logic            wr_valid;
    logic            wr_ready;
    logic [4:0]      wr_addr;
    logic [W-1:0]    wr_data;
    logic            clr_req;
    logic            clr_busy;
    logic [32*W-1:0] regs_flat;

    register_bank_32 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .regs_flat (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  a;
        logic [31:0] d;
        logic [4:0]  ca;
        logic [31:0] ce;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] model [32];
    int          nvec;
    int          nfail;

    task automatic chk(input string name, input logic [32*W-1:0] act, input logic [32*W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32*W-1:0] model_flat();
        logic [32*W-1:0] f;
        f = '0;
        for (int i = 0; i < 32; i++) f[i*W +: W] = model[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        if (!(R0Z && a == 5'd0)) model[a] = d;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i + 1));
    endtask

    // Runs one clear. with_write: a write to 31 shares the clr_req edge.
    // inject: a write to 3 and repeated clr_req are driven during CLEAR.
    task automatic do_clear(input bit with_write, input bit inject);
        int c;
        clr_req = 1'b1;
        if (with_write) begin
            wr_valid = 1'b1;
            wr_addr  = 5'd31;
            wr_data  = 32'hA5A5_A5A5;
        end
        @(posedge clk); #1;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        if (with_write) begin
            model[31] = 32'hA5A5_A5A5;
            chk("same_edge_write31", regs_flat[31*W +: W], 32'hA5A5_A5A5);
        end
        c = 0;
        while (clr_busy === 1'b1 && c < 40) begin
            chk("clear_ready_low", wr_ready, 1'b0);
            chk("clear_progress", regs_flat, model_flat());
            if (inject && c == 2) begin
                wr_valid = 1'b1;
                wr_addr  = 5'd3;
                wr_data  = 32'h55;
                clr_req  = 1'b1;
            end
            if (inject && c == 4) begin
                wr_valid = 1'b0;
                clr_req  = 1'b0;
            end
            if (c == 31) clr_req = 1'b1;
            @(posedge clk); #1;
            c++;
            if (c <= 32) model[c-1] = 32'h0;
        end
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        chk("busy_length", 32'(c), 32'd32);
        chk("ready_after_clear", wr_ready, 1'b1);
        chk("busy_after_clear", clr_busy, 1'b0);
        chk("all_zero_after_clear", regs_flat, '0);
        @(posedge clk); #1;
        chk("no_restart_busy", clr_busy, 1'b0);
    endtask

    initial begin
        nvec = 0;
        nfail = 0;
        tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 5'd5,  32'hFFFF_FFFF, 5'd5,  32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 5'd7,  32'h1234_5678, 5'd7,  32'h1234_5678};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
        tbl[4] = '{1'b1, 5'd0,  32'h0000_1234, 5'd0,  R0EXP};
        tbl[5] = '{1'b1, 5'd5,  32'h0BAD_F00D, 5'd5,  32'h0BAD_F00D};
        tbl[6] = '{1'b0, 5'd0,  32'h5555_5555, 5'd7,  32'h1234_5678};
        tbl[7] = '{1'b1, 5'd1,  32'h8000_0001, 5'd1,  32'h8000_0001};

        model_clear();
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = '0;
        clr_req  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", wr_ready, 1'b1);
        chk("reset_busy", clr_busy, 1'b0);
        chk("reset_regs", regs_flat, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", wr_ready, 1'b1);
        chk("post_reset_regs", regs_flat, '0);

        // Single-write vectors
        for (int k = 0; k < 8; k++) begin
            wr_valid = tbl[k].wv;
            wr_addr  = tbl[k].a;
            wr_data  = tbl[k].d;
            wr_valid = tbl[k].wv;
            @(posedge clk); #1;
            wr_valid = 1'b0;
            if (tbl[k].wv && !(R0Z && tbl[k].a == 5'd0)) model[tbl[k].a] = tbl[k].d;
            chk("vec_ready", wr_ready, 1'b1);
            chk("vec_busy", clr_busy, 1'b0);
            chk("vec_slice", regs_flat[tbl[k].ca*W +: W], tbl[k].ce);
            chk("vec_flat", regs_flat, model_flat());
        end

        // Full bank then a plain clear
        fill_all();
        chk("fill_flat", regs_flat, model_flat());
        do_clear(1'b0, 1'b0);

        // Writes and clr_req during CLEAR are ignored
        do_write(5'd3, 32'h77);
        do_write(5'd20, 32'h99);
        do_clear(1'b0, 1'b1);

        // Write and clr_req on the same IDLE edge
        do_clear(1'b1, 1'b0);

        // Reset asserted mid-clear at counter = 10
        fill_all();
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midclear_busy", clr_busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        chk("async_reset_busy", clr_busy, 1'b0);
        chk("async_reset_ready", wr_ready, 1'b1);
        chk("async_reset_regs", regs_flat, '0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("release_busy", clr_busy, 1'b0);
        chk("release_ready", wr_ready, 1'b1);
        do_write(5'd9, 32'h0000_CAFE);
        chk("write_after_reset", regs_flat[9*W +: W], 32'h0000_CAFE);
        chk("flat_after_reset", regs_flat, model_flat());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_bank_32.md
REGISTER_BANK_32 -- requirements
Module: register_bank_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the bit width of each of the 32 registers.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port wr_valid  input  1  write request valid.
REQ-005 SHALL have port wr_ready  output  1  write port can accept; high only in IDLE.
REQ-006 SHALL have port wr_addr  input  5  target register index 0..31.
REQ-007 SHALL have port wr_data  input  WIDTH  write value.
REQ-008 SHALL have port clr_req  input  1  request a sequential clear of all 32 registers.
REQ-009 SHALL have port clr_busy  output  1  high while the clear sequence runs.
REQ-010 SHALL have port regs_flat  output  32*WIDTH  register contents; bits [i*WIDTH +: WIDTH] are register i and feed input_i of the downstream 32-to-1 select mux.

Function
REQ-011 SHALL hold 32 WIDTH-bit registers and drive regs_flat directly from register outputs, with no combinational path from wr_* to regs_flat.
REQ-012 SHALL accept a write on a rising edge when wr_valid && wr_ready, updating register wr_addr to wr_data; the new value appears on regs_flat immediately after that edge, one-cycle latency.
REQ-013 SHALL leave every register other than wr_addr unchanged on an accepted write.
REQ-014 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-015 SHALL drive wr_ready = 1 and clr_busy = 0 in IDLE, and wr_ready = 0 and clr_busy = 1 in CLEAR, both decoded from state only.
REQ-016 SHALL move IDLE -> CLEAR on a rising edge where clr_req = 1, loading the 5-bit clear counter with 0.
REQ-017 SHALL, in CLEAR, zero register[counter] on each rising edge and then increment the counter; on the edge where counter = 31, zero register 31, return to IDLE, and reset the counter to 0 (exactly 32 cycles in CLEAR).
REQ-018 SHALL ignore clr_req while in CLEAR; no restart and no extension.
REQ-019 SHALL ignore wr_valid while in CLEAR; no register changes except by the clear sequence.
REQ-020 SHALL, when clr_req and wr_valid are both high in IDLE, perform the write on that edge and enter CLEAR, so the written register is later zeroed by the sequence.
REQ-021 SHALL treat wr_addr and wr_data as don't-care when wr_valid = 0.

Reset
REQ-022 SHALL, while reset_n = 0, asynchronously force all 32 registers to 0, the state to IDLE, and the clear counter to 0.
REQ-023 SHALL present wr_ready = 1, clr_busy = 0, and regs_flat = 0 during and immediately after reset.
REQ-024 SHALL abort an in-progress clear on reset assertion, with no residual busy cycles after release.

Configuration
REQ-025 SHALL honour macro REG0_ZERO_EN: when defined, register 0 SHALL read as 0 at all times, and a write to address 0 SHALL complete the handshake with its data discarded.
REQ-026 SHALL, without REG0_ZERO_EN, treat register 0 as an ordinary writable register.

Verification
REQ-027 Reset then write addr 5 = 0xDEADBEEF (WIDTH 32) -> slice 5 = 0xDEADBEEF on the cycle after the edge; all other slices remain 0.
REQ-028 Fill all 32 registers with value i+1, pulse clr_req for 1 cycle -> clr_busy high for exactly 32 cycles; register k reads 0 from k+1 cycles after entry to CLEAR; wr_ready returns to 1 on cycle 33.
REQ-029 During CLEAR, assert wr_valid with addr 3 = 0x55 and pulse clr_req again -> wr_ready = 0, no write, busy length still 32, register 3 ends at 0.
REQ-030 In IDLE, assert clr_req and wr_valid (addr 31 = 0xA5A5A5A5) on the same edge -> write lands, CLEAR starts, register 31 reads 0 after the 32nd clear cycle.
REQ-031 Assert reset_n low mid-clear at counter = 10 -> all slices 0, clr_busy 0, and wr_ready 1 asynchronously; the next write after release succeeds with normal latency.
REQ-032 Write addr 0 = 0x1234 -> slice 0 reads 0 with REG0_ZERO_EN defined and 0x1234 without it; wr_ready = 1 in both builds.
